// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared word type, bus memory FSM states and idle read pattern
package chiplet_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } bus_mem_state_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/bus_protocol_if.sv
// rtl/bus_protocol_if.sv - simple stalling read/write bus between a master and a peripheral
interface bus_protocol_if;

    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        request_stall;

    modport peripheral_vital (
        input  addr,
        input  ren,
        input  wen,
        input  wdata,
        input  strobe,
        output rdata,
        output request_stall
    );

    modport master_vital (
        output addr,
        output ren,
        output wen,
        output wdata,
        output strobe,
        input  rdata,
        input  request_stall
    );

endinterface

// File: rtl/byte_mask_expand.sv
// rtl/byte_mask_expand.sv - expands 4 byte enables into a 32-bit bit mask
module byte_mask_expand (
    input  logic [3:0]  strobe_i,
    output logic [31:0] mask_o
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign mask_o[8*i +: 8] = {8{strobe_i[i]}};
    end

endmodule

// File: rtl/bus_memory.sv
// rtl/bus_memory.sv - flop-array bus memory with programmable read latency and byte-merged writes
// Optional address range checking: BUS_MEMORY_RANGE_CHECK_EN
module bus_memory
    import chiplet_types_pkg::*;
#(
    parameter int NUM_WORDS = 128,
    parameter int READ_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    bus_protocol_if.peripheral_vital  bus_if,
    output logic                      range_err
);

    localparam int ADDR_LEN = $clog2(NUM_WORDS);

    bus_mem_state_t      state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] idx_q, idx_d;
    logic                bad_q, bad_d;
    word_t               mem_q [NUM_WORDS];

    word_t               wmask;
    logic [ADDR_LEN-1:0] idx;
    logic                oob;
    logic                oob_hit;
    logic                wr_en;
    logic                unused_addr;

    assign idx         = bus_if.addr[2 +: ADDR_LEN];
    assign unused_addr = ^{bus_if.addr[1:0], bus_if.addr[31:2+ADDR_LEN]};

`ifdef BUS_MEMORY_RANGE_CHECK_EN
    assign oob = (bus_if.addr[31:2] >= 30'(NUM_WORDS));
`else
    assign oob = 1'b0;
`endif

    byte_mask_expand u_mask (
        .strobe_i (bus_if.strobe),
        .mask_o   (wmask)
    );

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        idx_d                = idx_q;
        bad_d                = bad_q;
        wr_en                = 1'b0;
        oob_hit              = 1'b0;
        bus_if.request_stall = 1'b0;
        bus_if.rdata         = BAD_WORD;

        unique case (state_q)
            IDLE: begin
                if (bus_if.wen) begin
                    wr_en   = !oob;
                    oob_hit = oob;
                end else if (bus_if.ren) begin
                    oob_hit = oob;
                    if (READ_LAT == 0) begin
                        if (!oob) bus_if.rdata = mem_q[idx];
                    end else begin
                        bus_if.request_stall = 1'b1;
                        idx_d   = idx;
                        bad_d   = oob;
                        cnt_d   = 3'(READ_LAT - 1);
                        // A single wait cycle is the accept cycle itself, so skip BUSY.
                        state_d = (READ_LAT == 1) ? RESP : BUSY;
                    end
                end
            end
            BUSY: begin
                bus_if.request_stall = 1'b1;
                if (!bus_if.ren) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = RESP;
                end
            end
            RESP: begin
                if (!bad_q) bus_if.rdata = mem_q[idx_q];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            bus_if.request_stall = 1'b0;
            bus_if.rdata         = BAD_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            if (wr_en) mem_q[idx] <= (mem_q[idx] & ~wmask) | (bus_if.wdata & wmask);
        end
    end

`ifdef BUS_MEMORY_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          range_err_q <= 1'b0;
        else if (oob_hit) range_err_q <= 1'b1;
    end

    assign range_err = range_err_q;
`else
    logic unused_oob;

    assign unused_oob = oob_hit;
    assign range_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_memory.sv
// tb/tb_bus_memory.sv - four latency lanes (0..3) checked every cycle against a behavioural model
module tb_bus_memory;

    localparam int          NL  = 4;
    localparam int          NW  = 128;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] addr_a [NL];
    logic [31:0] wdata_a[NL];
    logic [31:0] rdata_a[NL];
    logic [3:0]  strb_a [NL];
    logic        ren_a  [NL];
    logic        wen_a  [NL];
    logic        stall_a[NL];
    logic        rerr_a [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        bus_protocol_if bif ();
        assign bif.addr    = addr_a[g];
        assign bif.ren     = ren_a[g];
        assign bif.wen     = wen_a[g];
        assign bif.wdata   = wdata_a[g];
        assign bif.strobe  = strb_a[g];
        assign rdata_a[g]  = bif.rdata;
        assign stall_a[g]  = bif.request_stall;

        bus_memory #(.NUM_WORDS(NW), .READ_LAT(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus_if    (bif),
            .range_err (rerr_a[g])
        );
    end

    // Model: per-lane memory image, and the age (cycles since acceptance) of a pending read.
    logic [31:0] mmem [NL][NW];
    int          age  [NL];
    int          pidx [NL];
    bit          pbad [NL];
    bit          mrerr[NL];

    int errors = 0;
    int checks = 0;

    function automatic bit is_oob(logic [31:0] a);
`ifdef BUS_MEMORY_RANGE_CHECK_EN
        return a[31:2] >= 30'(NW);
`else
        return (a[1:0] == 2'b00) && 1'b0;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        #4;
        for (int l = 0; l < NL; l++) begin
            logic [31:0] er;
            logic        es;
            int          idx;
            bit          oob;
            idx = int'(addr_a[l][8:2]);
            oob = is_oob(addr_a[l]);
            er  = BAD;
            es  = 1'b0;
            if (rst) begin
                er = BAD;
            end else if (age[l] > 0) begin
                if (age[l] == l) er = pbad[l] ? BAD : mmem[l][pidx[l]];
                else             es = 1'b1;
            end else if (!wen_a[l] && ren_a[l]) begin
                if (l == 0) er = oob ? BAD : mmem[l][idx];
                else        es = 1'b1;
            end
            chk($sformatf("lane%0d rdata", l), rdata_a[l], er);
            chk($sformatf("lane%0d stall", l), 32'(stall_a[l]), 32'(es));
            chk($sformatf("lane%0d range_err", l), 32'(rerr_a[l]), 32'(mrerr[l]));

            if (rst) begin
                age[l]   = 0;
                mrerr[l] = 1'b0;
                for (int w = 0; w < NW; w++) mmem[l][w] = '0;
            end else if (age[l] > 0) begin
                if (age[l] == l || !ren_a[l]) age[l] = 0;
                else                          age[l]++;
            end else if (wen_a[l]) begin
                if (oob) mrerr[l] = 1'b1;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (strb_a[l][b]) mmem[l][idx][8*b +: 8] = wdata_a[l][8*b +: 8];
                end
            end else if (ren_a[l]) begin
                if (oob) mrerr[l] = 1'b1;
                if (l > 0) begin
                    age[l]  = 1;
                    pidx[l] = idx;
                    pbad[l] = oob;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(int l, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        addr_a[l]  = a;
        wdata_a[l] = d;
        strb_a[l]  = s;
        wen_a[l]   = 1'b1;
        ren_a[l]   = 1'b0;
        step();
        wen_a[l]   = 1'b0;
    endtask

    task automatic do_read(int l, logic [31:0] a, output logic [31:0] d, output int ns);
        bit done;
        done      = 1'b0;
        addr_a[l] = a;
        ren_a[l]  = 1'b1;
        wen_a[l]  = 1'b0;
        ns        = 0;
        d         = 'x;
        for (int k = 0; k < 12 && !done; k++) begin
            #2;
            if (stall_a[l]) ns++;
            else begin
                d    = rdata_a[l];
                done = 1'b1;
            end
            step();
        end
        ren_a[l] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL lane%0d read timeout: got stall for %0d cycles expected a response", l, ns);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[31:9] = 23'($urandom);
        return a;
    endfunction

    initial begin
        logic [31:0] d;
        int          ns;
        int          op;

        rst = 1'b1;
        for (int l = 0; l < NL; l++) begin
            addr_a[l] = '0; wdata_a[l] = '0; strb_a[l] = '0;
            ren_a[l]  = 1'b0; wen_a[l] = 1'b0;
            age[l] = 0; pidx[l] = 0; pbad[l] = 1'b0; mrerr[l] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;

        #2;
        chk("idle rdata", rdata_a[0], BAD);
        chk("idle stall", 32'(stall_a[0]), 32'd0);
        step();

        do_read(0, 32'h40, d, ns);
        chk("lat0 unwritten rdata", d, 32'h0);
        chk("lat0 stall cycles", 32'(ns), 32'd0);

        do_write(2, 32'h10, 32'hDEADBEEF, 4'hF);
        do_read(2, 32'h10, d, ns);
        chk("lat2 rdata", d, 32'hDEADBEEF);
        chk("lat2 stall cycles", 32'(ns), 32'd2);

        do_write(2, 32'h10, 32'h11223344, 4'b0101);
        do_read(2, 32'h10, d, ns);
        chk("merge rdata", d, 32'hDE22BE44);
        chk("model merge word", mmem[2][4], 32'hDE22BE44);

        addr_a[1] = 32'h20; wdata_a[1] = 32'hCAFEF00D; strb_a[1] = 4'hF;
        ren_a[1] = 1'b1; wen_a[1] = 1'b1;
        #2;
        chk("ren+wen rdata", rdata_a[1], BAD);
        chk("ren+wen stall", 32'(stall_a[1]), 32'd0);
        step();
        ren_a[1] = 1'b0; wen_a[1] = 1'b0;
        do_read(1, 32'h20, d, ns);
        chk("ren+wen readback", d, 32'hCAFEF00D);
        chk("lat1 stall cycles", 32'(ns), 32'd1);

        do_write(3, 32'h10, 32'h12345678, 4'hF);
        addr_a[3] = 32'h10; ren_a[3] = 1'b1;
        step();
        step();
        rst = 1'b1;
        #2;
        chk("rst mid-read stall", 32'(stall_a[3]), 32'd0);
        chk("rst mid-read rdata", rdata_a[3], BAD);
        step();
        rst = 1'b0; ren_a[3] = 1'b0;
        step();
        do_read(3, 32'h10, d, ns);
        chk("after rst rdata", d, 32'h0);
        chk("lat3 stall cycles", 32'(ns), 32'd3);
        chk("model word after rst", mmem[3][4], 32'h0);

        do_write(0, 32'h200, 32'h55AA55AA, 4'hF);
`ifdef BUS_MEMORY_RANGE_CHECK_EN
        do_read(0, 32'h200, d, ns);
        chk("oob read rdata", d, BAD);
        chk("oob range_err", 32'(rerr_a[0]), 32'd1);
        do_read(0, 32'h0, d, ns);
        chk("oob write dropped", d, 32'h0);
        chk("range_err held", 32'(rerr_a[0]), 32'd1);
`else
        do_read(0, 32'h0, d, ns);
        chk("alias word0", d, 32'h55AA55AA);
        chk("alias range_err", 32'(rerr_a[0]), 32'd0);
`endif

        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int l = 0; l < NL; l++) begin
                addr_a[l]  = rand_addr();
                wdata_a[l] = $urandom;
                strb_a[l]  = 4'($urandom);
                if (age[l] > 0) begin
                    ren_a[l] = ($urandom_range(0, 15) != 0);
                    wen_a[l] = 1'($urandom);
                end else begin
                    op = $urandom_range(0, 9);
                    ren_a[l] = (op < 4) || (op == 8);
                    wen_a[l] = (op >= 4) && (op <= 8);
                end
            end
            step();
        end

        rst = 1'b0;
        for (int l = 0; l < NL; l++) begin
            ren_a[l] = 1'b0;
            wen_a[l] = 1'b0;
        end
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
